irrigation_scheduler: RTL and testbench

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

---
 rtl/irrigation_pkg.sv | 36 +++
 rtl/bcd_down_timer.sv | 53 +++++
 rtl/irrigation_scheduler.sv | 179 +++++++++++++++++
 tb/tb_irrigation_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared encodings and constants for the irrigation scheduler.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IRRIGATE = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_REFILL   = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    typedef enum logic {
        MODE_DRIP     = 1'b0,
        MODE_SPRINKLE = 1'b1
    } mode_t;

    // Largest legal value of each BCD digit of the mm:ss timer
    localparam logic [3:0] SEC_U_MAX = 4'd9;
    localparam logic [3:0] SEC_D_MAX = 4'd5;
    localparam logic [3:0] MIN_U_MAX = 4'd9;
    localparam logic [3:0] MIN_D_MAX = 4'd3;

    // Clean ticks required before leaving FAULT
    localparam int FAULT_CLEAR_TICKS = 3;

    // Converts a second count into packed BCD {min_d, min_u, sec_d, sec_u}.
    // Only ever called on parameters, so it folds away at elaboration.
    function automatic logic [15:0] sec_to_bcd(input int sec);
        int mins;
        int secs;
        mins = sec / 60;
        secs = sec % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// Loadable mm:ss BCD down counter; decrements on tick and holds at 00:00.
module bcd_down_timer
    import irrigation_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        tick,
    output logic [15:0] value,
    output logic        zero
);

    localparam logic [15:0] DIGIT_MAX = {MIN_D_MAX, MIN_U_MAX, SEC_D_MAX, SEC_U_MAX};

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic [15:0] dec_value;
    logic        zero_now;

    assign zero_now = (value_q == 16'h0000);

    // Each digit borrows when a decrement is pending and every lower digit is 0;
    // a borrowing digit at 0 wraps to its own maximum.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam logic [15:0] LOWER_MASK = 16'((32'd1 << (gi * 4)) - 32'd1);
        logic [3:0] digit;
        logic       borrow_in;
        assign digit     = value_q[gi*4 +: 4];
        assign borrow_in = tick & ~zero_now & ((value_q & LOWER_MASK) == 16'h0000);
        assign dec_value[gi*4 +: 4] = !borrow_in       ? digit :
                                      (digit == 4'd0)  ? DIGIT_MAX[gi*4 +: 4] :
                                                         digit - 4'd1;
    end

    // Load has priority over decrement
    always_comb begin
        value_d = load ? load_value : dec_value;
    end

    // Timer register
    always_ff @(posedge clk) begin
        if (srst) begin
            value_q <= 16'h0000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = zero_now;

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation controller: chooses sprinkler or dripper, times the run and
// soak pause, refills the tank and locks out on inconsistent level probes.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int SPRINKLE_SEC = 120,
    parameter int DRIP_SEC     = 300,
    parameter int PAUSE_SEC    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       low_water_level,
    input  logic       mid_water_level,
    input  logic       high_water_level,
    input  logic       earth_humidity,
    input  logic       air_humidity,
    input  logic       low_temperature,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       water_supply_valvule,
    output logic       alarm,
    output logic       busy,
    output logic [3:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [3:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic [2:0] state
);

    localparam logic [15:0] SPRINKLE_BCD = sec_to_bcd(SPRINKLE_SEC);
    localparam logic [15:0] DRIP_BCD     = sec_to_bcd(DRIP_SEC);
    localparam logic [15:0] PAUSE_BCD    = sec_to_bcd(PAUSE_SEC);
    localparam logic [1:0]  FAULT_LAST   = 2'(FAULT_CLEAR_TICKS - 1);

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [1:0]  fault_cnt_q, fault_cnt_d;
    logic        sprink_q, sprink_d;
    logic        drip_q, drip_d;
    logic        supply_q, supply_d;
    logic        alarm_q, alarm_d;
    logic        busy_q, busy_d;

    logic        conflict;
    logic        tmr_load;
    logic [15:0] tmr_load_value;
    logic        tmr_tick;
    logic [15:0] tmr_value;
    logic        tmr_zero;

    assign conflict = (high_water_level & ~mid_water_level) |
                      (mid_water_level & ~low_water_level);

    bcd_down_timer u_timer (
        .clk        (clock),
        .srst       (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .tick       (tmr_tick),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    // Next state, mode latch, fault counter and timer control
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        fault_cnt_d    = fault_cnt_q;
        tmr_load       = 1'b0;
        tmr_load_value = 16'h0000;
        tmr_tick       = 1'b0;

        if (state_q == ST_FAULT) begin
            // Only a run of clean ticks gets us out; any conflict restarts it
            if (conflict) begin
                fault_cnt_d = 2'd0;
            end else if (tick) begin
                if (fault_cnt_q == FAULT_LAST) begin
                    state_d     = ST_IDLE;
                    fault_cnt_d = 2'd0;
                end else begin
                    fault_cnt_d = fault_cnt_q + 2'd1;
                end
            end
        end else if (conflict) begin
            state_d     = ST_FAULT;
            fault_cnt_d = 2'd0;
            tmr_load    = 1'b1;
        end else if (!low_water_level && state_q != ST_REFILL) begin
            state_d  = ST_REFILL;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!earth_humidity) begin
                        state_d  = ST_IRRIGATE;
                        tmr_load = 1'b1;
                        if (~air_humidity & ~low_temperature & mid_water_level) begin
                            mode_d         = MODE_SPRINKLE;
                            tmr_load_value = SPRINKLE_BCD;
                        end else begin
                            mode_d         = MODE_DRIP;
                            tmr_load_value = DRIP_BCD;
                        end
                    end
                end
                ST_IRRIGATE: begin
                    if (earth_humidity || (tick && tmr_zero)) begin
                        state_d        = ST_PAUSE;
                        tmr_load       = 1'b1;
                        tmr_load_value = PAUSE_BCD;
                    end else begin
                        tmr_tick = tick;
                    end
                end
                ST_PAUSE: begin
                    if (tick && tmr_zero) begin
                        state_d  = ST_IDLE;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_tick = tick;
                    end
                end
                ST_REFILL: begin
                    if (high_water_level) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end
            endcase
        end
    end

    // Output values decoded from the upcoming state so they register with it
    always_comb begin
        sprink_d = (state_d == ST_IRRIGATE) && (mode_d == MODE_SPRINKLE);
        drip_d   = (state_d == ST_IRRIGATE) && (mode_d == MODE_DRIP);
        supply_d = (state_d == ST_REFILL);
        alarm_d  = (state_d == ST_FAULT) || !mid_water_level;
        busy_d   = (state_d == ST_IRRIGATE) || (state_d == ST_PAUSE) ||
                   (state_d == ST_REFILL);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_DRIP;
            fault_cnt_q <= 2'd0;
            sprink_q    <= 1'b0;
            drip_q      <= 1'b0;
            supply_q    <= 1'b0;
            alarm_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fault_cnt_q <= fault_cnt_d;
            sprink_q    <= sprink_d;
            drip_q      <= drip_d;
            supply_q    <= supply_d;
            alarm_q     <= alarm_d;
            busy_q      <= busy_d;
        end
    end

    assign splinker_bomb        = sprink_q;
    assign dripper_valvule      = drip_q;
    assign water_supply_valvule = supply_q;
    assign alarm                = alarm_q;
    assign busy                 = busy_q;
    assign state                = state_q;
    assign {minutes_d, minutes_u, seconds_d, seconds_u} = tmr_value;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler plus a direct check of the timer.
module tb_irrigation_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] lvl = 3'b111;   // {high, mid, low}
    logic       earth = 1'b1;
    logic       air = 1'b0;
    logic       cold = 1'b0;

    logic       splinker_bomb, dripper_valvule, water_supply_valvule, alarm, busy;
    logic [3:0] minutes_d, minutes_u, seconds_d, seconds_u;
    logic [2:0] state;

    logic        t_load = 1'b0;
    logic [15:0] t_val = 16'h0000;
    logic        t_tick = 1'b0;
    logic [15:0] t_value;
    logic        t_zero;

    int checks = 0;
    int errors = 0;

    logic [23:0] sb_q[$];
    logic [16:0] tsb_q[$];
    logic [23:0] exp_v;
    logic [16:0] texp_v;

    always #5 clk = ~clk;

    irrigation_scheduler dut (
        .clock                (clk),
        .reset                (rst),
        .tick                 (tick),
        .low_water_level      (lvl[0]),
        .mid_water_level      (lvl[1]),
        .high_water_level     (lvl[2]),
        .earth_humidity       (earth),
        .air_humidity         (air),
        .low_temperature      (cold),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .water_supply_valvule (water_supply_valvule),
        .alarm                (alarm),
        .busy                 (busy),
        .minutes_d            (minutes_d),
        .minutes_u            (minutes_u),
        .seconds_d            (seconds_d),
        .seconds_u            (seconds_u),
        .state                (state)
    );

    bcd_down_timer u_tmr (
        .clk        (clk),
        .srst       (rst),
        .load       (t_load),
        .load_value (t_val),
        .tick       (t_tick),
        .value      (t_value),
        .zero       (t_zero)
    );

    function automatic logic [15:0] to_bcd(input int s);
        logic [3:0] a, b, c, d;
        a = 4'((s / 60) / 10);
        b = 4'((s / 60) % 10);
        c = 4'((s % 60) / 10);
        d = 4'((s % 60) % 10);
        return {a, b, c, d};
    endfunction

    // Expected vector: {state, sprinkler, dripper, supply, alarm, busy, mm:ss}
    function automatic logic [23:0] mk(input logic [2:0] st, input logic sp, input logic dr,
                                       input logic ws, input logic al, input logic bz,
                                       input int secs);
        return {st, sp, dr, ws, al, bz, to_bcd(secs)};
    endfunction

    function automatic logic [23:0] obs_v();
        return {state, splinker_bomb, dripper_valvule, water_supply_valvule, alarm, busy,
                minutes_d, minutes_u, seconds_d, seconds_u};
    endfunction

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; lvl = 3'b101; earth = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
            cyc(1'b1);
            exp_v = sb_q.pop_front(); checks++;
            if (obs_v() !== exp_v) begin
                errors++; $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs_v(), exp_v);
            end
        end
        rst = 1'b0; lvl = 3'b111; earth = 1'b1;
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", obs_v(), exp_v);
        end
    endtask

    task automatic test_sprinkler;
        lvl = 3'b111; air = 1'b0; cold = 1'b0; earth = 1'b0;
        // tick coinciding with the start must not decrement the fresh load
        sb_q.push_back(mk(3'd1, 1, 0, 0, 0, 1, 120));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL spr_start got=%h exp=%h", obs_v(), exp_v);
        end
        for (int k = 1; k <= 120; k++) begin
            sb_q.push_back(mk(3'd1, 1, 0, 0, 0, 1, 120 - k));
            cyc(1'b1);
            exp_v = sb_q.pop_front(); checks++;
            if (obs_v() !== exp_v) begin
                errors++; $display("FAIL spr_tick k=%0d got=%h exp=%h", k, obs_v(), exp_v);
            end
            cyc(1'b0);
        end
        sb_q.push_back(mk(3'd2, 0, 0, 0, 0, 1, 30));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL spr_to_pause got=%h exp=%h", obs_v(), exp_v);
        end
        earth = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            sb_q.push_back(mk(3'd2, 0, 0, 0, 0, 1, 30 - k));
            cyc(1'b1);
            exp_v = sb_q.pop_front(); checks++;
            if (obs_v() !== exp_v) begin
                errors++; $display("FAIL pause_tick k=%0d got=%h exp=%h", k, obs_v(), exp_v);
            end
            cyc(1'b0);
        end
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL pause_to_idle got=%h exp=%h", obs_v(), exp_v);
        end
    endtask

    task automatic test_dripper;
        lvl = 3'b011; air = 1'b1; cold = 1'b0; earth = 1'b0;
        sb_q.push_back(mk(3'd1, 0, 1, 0, 0, 1, 300));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL drip_start got=%h exp=%h", obs_v(), exp_v);
        end
        for (int k = 1; k <= 163; k++) begin
            sb_q.push_back(mk(3'd1, 0, 1, 0, 0, 1, 300 - k));
            cyc(1'b1);
            exp_v = sb_q.pop_front(); checks++;
            if (obs_v() !== exp_v) begin
                errors++; $display("FAIL drip_tick k=%0d got=%h exp=%h", k, obs_v(), exp_v);
            end
            cyc(1'b0);
        end
        // at 02:17 the soil turns wet
        earth = 1'b1;
        sb_q.push_back(mk(3'd2, 0, 0, 0, 0, 1, 30));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL drip_wet_pause got=%h exp=%h", obs_v(), exp_v);
        end
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 31; k++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL drip_pause_done got=%h exp=%h", obs_v(), exp_v);
        end
    endtask

    task automatic test_refill;
        lvl = 3'b111; air = 1'b1; earth = 1'b0;
        sb_q.push_back(mk(3'd1, 0, 1, 0, 0, 1, 300));
        cyc(1'b0);
        sb_q.push_back(mk(3'd1, 0, 1, 0, 0, 1, 299));
        cyc(1'b1);
        for (int i = 0; i < 2; i++) begin
            exp_v = sb_q.pop_front(); checks++;
            if (i == 0) begin
                // the first expectation belongs to the previous cycle; compare
                // the current output against the second only
                exp_v = sb_q.pop_front();
            end
            if (obs_v() !== exp_v) begin
                errors++; $display("FAIL refill_run i=%0d got=%h exp=%h", i, obs_v(), exp_v);
            end
            if (i == 0) break;
        end
        lvl = 3'b000;
        sb_q.push_back(mk(3'd3, 0, 0, 1, 1, 1, 0));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL refill_enter got=%h exp=%h", obs_v(), exp_v);
        end
        lvl = 3'b001;
        sb_q.push_back(mk(3'd3, 0, 0, 1, 1, 1, 0));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL refill_hold got=%h exp=%h", obs_v(), exp_v);
        end
        lvl = 3'b111; earth = 1'b1;
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL refill_exit got=%h exp=%h", obs_v(), exp_v);
        end
    endtask

    task automatic test_fault;
        logic [2:0] lvl_tab [8]  = '{3'b101, 3'b111, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b111};
        logic       tick_tab [8] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1};
        logic [2:0] st_tab [8]   = '{3'd4,   3'd4,   3'd4,   3'd4,   3'd4,   3'd4,   3'd4,   3'd0};
        earth = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lvl = lvl_tab[i];
            sb_q.push_back(mk(st_tab[i], 0, 0, 0, (st_tab[i] == 3'd4), 0, 0));
            cyc(tick_tab[i]);
            exp_v = sb_q.pop_front(); checks++;
            if (obs_v() !== exp_v) begin
                errors++; $display("FAIL fault_seq i=%0d got=%h exp=%h", i, obs_v(), exp_v);
            end
        end
    endtask

    task automatic test_conflict_irrigate;
        lvl = 3'b111; air = 1'b0; cold = 1'b0; earth = 1'b0;
        sb_q.push_back(mk(3'd1, 1, 0, 0, 0, 1, 120));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL conf_irr_start got=%h exp=%h", obs_v(), exp_v);
        end
        lvl = 3'b110;
        sb_q.push_back(mk(3'd4, 0, 0, 0, 1, 0, 0));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL conf_irr_fault got=%h exp=%h", obs_v(), exp_v);
        end
        lvl = 3'b111; earth = 1'b1;
        sb_q.push_back(mk(3'd4, 0, 0, 0, 1, 0, 0));
        cyc(1'b1);
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL conf_irr_two_ticks got=%h exp=%h", obs_v(), exp_v);
        end
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL conf_irr_clear got=%h exp=%h", obs_v(), exp_v);
        end
    endtask

    task automatic test_reset_mid;
        lvl = 3'b111; air = 1'b0; cold = 1'b0; earth = 1'b0;
        cyc(1'b0);
        cyc(1'b1);
        sb_q.push_back(mk(3'd1, 1, 0, 0, 0, 1, 118));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL rstmid_run got=%h exp=%h", obs_v(), exp_v);
        end
        rst = 1'b1;
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL rstmid_irrigate got=%h exp=%h", obs_v(), exp_v);
        end
        rst = 1'b0; earth = 1'b1; lvl = 3'b000;
        sb_q.push_back(mk(3'd3, 0, 0, 1, 1, 1, 0));
        cyc(1'b0);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL rstmid_refill_enter got=%h exp=%h", obs_v(), exp_v);
        end
        rst = 1'b1;
        sb_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b1);
        exp_v = sb_q.pop_front(); checks++;
        if (obs_v() !== exp_v) begin
            errors++; $display("FAIL rstmid_refill got=%h exp=%h", obs_v(), exp_v);
        end
        rst = 1'b0; lvl = 3'b111;
        cyc(1'b0);
    endtask

    task automatic test_timer_borrow;
        logic [15:0] load_tab [5] = '{16'h1000, 16'h0010, 16'h0100, 16'h0000, 16'h3959};
        logic [15:0] dec_tab  [5] = '{16'h0959, 16'h0009, 16'h0059, 16'h0000, 16'h3958};
        for (int i = 0; i < 5; i++) begin
            t_load = 1'b1; t_val = load_tab[i];
            tsb_q.push_back({load_tab[i], (load_tab[i] == 16'h0000)});
            cyc(1'b0);
            t_load = 1'b0;
            texp_v = tsb_q.pop_front(); checks++;
            if ({t_value, t_zero} !== texp_v) begin
                errors++; $display("FAIL tmr_load i=%0d got=%h exp=%h", i, {t_value, t_zero}, texp_v);
            end
            t_tick = 1'b1;
            tsb_q.push_back({dec_tab[i], (dec_tab[i] == 16'h0000)});
            cyc(1'b0);
            t_tick = 1'b0;
            texp_v = tsb_q.pop_front(); checks++;
            if ({t_value, t_zero} !== texp_v) begin
                errors++; $display("FAIL tmr_dec i=%0d got=%h exp=%h", i, {t_value, t_zero}, texp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sprinkler();
        test_dripper();
        test_refill();
        test_fault();
        test_conflict_irrigate();
        test_reset_mid();
        test_timer_borrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
